// File: rtl/non_max_suppression.sv
// Canny non-maximum suppression stage.
// Consumes a raster stream of {dir, mag} words, keeps a three-row sliding
// window and emits the magnitude of each pixel only when it is a local
// maximum along its gradient direction; border pixels are forced to zero.
module non_max_suppression #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [9:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic [7:0] out_din,
    output logic       frame_done
);

    localparam int WIN   = 2 * WIDTH + 3;
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX + 1);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    // Window tap of neighbour A / B for each direction code.
    function automatic int tap_a(input int d);
        case (d)
            0:       return WIDTH;          // left
            1:       return 2;              // top-right
            2:       return 1;              // up
            default: return 0;              // top-left
        endcase
    endfunction

    function automatic int tap_b(input int d);
        case (d)
            0:       return WIDTH + 2;      // right
            1:       return 2 * WIDTH;      // bottom-left
            2:       return 2 * WIDTH + 1;  // down
            default: return 2 * WIDTH + 2;  // bottom-right
        endcase
    endfunction

    typedef enum logic {
        PROLOGUE,
        RUN
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   fill_cnt_reg;   // words popped so far in this frame
    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;
    logic               frame_done_reg;
    logic [9:0]         window_reg [0:WIN-1];

    logic               in_left;
    logic               src_ok;
    logic               advance;
    logic               pop;
    logic               shift_en;
    logic [9:0]         new_word;
    logic               last_col;
    logic               last_pix;
    logic               border;
    logic [7:0]         mag_c;
    logic [1:0]         dir_c;
    logic [3:0]         keep_dir;
    logic [7:0]         result;

    // Flow control: input is popped only while words remain in the frame;
    // once exhausted the window is fed zero padding without popping.
    always_comb begin
        in_left  = (fill_cnt_reg < CNT_W'(NPIX));
        src_ok   = in_left ? !in_empty : 1'b1;
        advance  = reset && (state_reg == RUN) && src_ok && !out_full;
        if (state_reg == PROLOGUE) begin
            pop = reset && !in_empty;
        end else begin
            pop = advance && in_left;
        end
        shift_en = (state_reg == PROLOGUE) ? pop : advance;
        new_word = in_left ? in_dout : 10'h000;
        last_col = (col_reg == COL_W'(WIDTH - 1));
        last_pix = last_col && (row_reg == ROW_W'(HEIGHT - 1));
    end

    assign mag_c = window_reg[WIDTH+1][7:0];
    assign dir_c = window_reg[WIDTH+1][9:8];

    // One comparator pair per direction; the centre's dir code picks one.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dir
            localparam int TA = tap_a(gi);
            localparam int TB = tap_b(gi);
            assign keep_dir[gi] = (mag_c >= window_reg[TA][7:0]) &&
                                  (mag_c >= window_reg[TB][7:0]);
        end
    endgenerate

    // Suppression result for the centre pixel at (row, col).
    always_comb begin
        border = (row_reg == '0) || (row_reg == ROW_W'(HEIGHT - 1)) ||
                 (col_reg == '0) || last_col;
        result = 8'h00;
        if (!border && keep_dir[dir_c]) begin
            result = mag_c;
        end
    end

    assign in_rd_en   = pop;
    assign out_wr_en  = advance;
    assign out_din    = advance ? result : 8'h00;
    assign frame_done = frame_done_reg;

    // Sliding window: entries move toward index 0, new word enters at the top.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIN; i++) begin
                window_reg[i] <= 10'h000;
            end
        end else if (shift_en) begin
            for (int i = 0; i < WIN - 1; i++) begin
                window_reg[i] <= window_reg[i+1];
            end
            window_reg[WIN-1] <= new_word;
        end
    end

    // Frame sequencing: fill the window, then one pixel per advance until the
    // last pixel, after which counters clear and the next frame can start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= PROLOGUE;
            fill_cnt_reg   <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                PROLOGUE: begin
                    if (pop) begin
                        fill_cnt_reg <= fill_cnt_reg + 1'b1;
                        if (fill_cnt_reg == CNT_W'(WIDTH + 1)) begin
                            state_reg <= RUN;
                        end
                    end
                end
                default: begin
                    if (advance) begin
                        if (pop) begin
                            fill_cnt_reg <= fill_cnt_reg + 1'b1;
                        end
                        if (last_pix) begin
                            state_reg      <= PROLOGUE;
                            fill_cnt_reg   <= '0;
                            col_reg        <= '0;
                            row_reg        <= '0;
                            frame_done_reg <= 1'b1;
                        end else if (last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_non_max_suppression.sv
// Testbench for non_max_suppression: lane 0 is an 8x6 instance, lane 1 a
// 16x8 instance. Stimulus pushes words into an input queue and expected
// results into a scoreboard queue; per-lane monitors pop and compare.
module tb_non_max_suppression;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic       in_rd_en   [2];
    logic       in_empty   [2];
    logic [9:0] in_dout    [2];
    logic       out_wr_en  [2];
    logic       out_full   [2];
    logic [7:0] out_din    [2];
    logic       frame_done [2];

    logic [9:0] in_q  [2][$];
    logic [8:0] exp_q [2][$];   // {last_pixel, expected magnitude}
    bit         stall_en [2];
    int         pops [2];
    int         pushes [2];
    int         fd_cnt [2];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] frame [0:127];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : lane
            localparam int LW = (gi == 0) ? 8 : 16;
            localparam int LH = (gi == 0) ? 6 : 8;

            non_max_suppression #(.WIDTH(LW), .HEIGHT(LH)) dut (
                .clock      (clock),
                .reset      (reset),
                .in_rd_en   (in_rd_en[gi]),
                .in_empty   (in_empty[gi]),
                .in_dout    (in_dout[gi]),
                .out_wr_en  (out_wr_en[gi]),
                .out_full   (out_full[gi]),
                .out_din    (out_din[gi]),
                .frame_done (frame_done[gi])
            );

            // Input FIFO model and backpressure generator.
            initial begin : drv
                in_empty[gi] = 1'b1;
                in_dout[gi]  = 10'h000;
                out_full[gi] = 1'b0;
                forever begin
                    @(negedge clock);
                    in_empty[gi] = (in_q[gi].size() == 0) ||
                                   (stall_en[gi] && ($urandom_range(0, 99) < 30));
                    in_dout[gi]  = (in_q[gi].size() != 0) ? in_q[gi][0] : 10'h000;
                    out_full[gi] = stall_en[gi] && ($urandom_range(0, 99) < 30);
                    #1;
                    if (in_rd_en[gi] === 1'b1) begin
                        if (in_empty[gi] || in_q[gi].size() == 0) begin
                            errors++;
                            $display("FAIL pop_when_empty lane%0d got rd_en=1 need rd_en=0", gi);
                        end else begin
                            void'(in_q[gi].pop_front());
                            pops[gi]++;
                        end
                    end
                end
            end

            // Output monitor: scoreboard compare and frame_done timing.
            initial begin : mon
                logic       pend;
                logic [8:0] e;
                pend = 1'b0;
                forever begin
                    @(negedge clock);
                    #2;
                    if (frame_done[gi] === 1'b1 || pend) begin
                        checks++;
                        if (frame_done[gi] !== pend) begin
                            errors++;
                            $display("FAIL frame_done lane%0d got %b need %b", gi, frame_done[gi], pend);
                        end
                    end
                    if (frame_done[gi] === 1'b1) fd_cnt[gi]++;
                    pend = 1'b0;
                    if (out_wr_en[gi] === 1'b1) begin
                        pushes[gi]++;
                        if (exp_q[gi].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write lane%0d got %0d need none", gi, out_din[gi]);
                        end else begin
                            e = exp_q[gi].pop_front();
                            checks++;
                            if (out_din[gi] !== e[7:0]) begin
                                errors++;
                                $display("FAIL pixel lane%0d got %0d need %0d", gi, out_din[gi], e[7:0]);
                            end else begin
                                $display("lane%0d write %0d ok", gi, out_din[gi]);
                            end
                            pend = e[8];
                        end
                    end
                end
            end
        end
    endgenerate

    // Reference: neighbour offsets of A (B is the mirror) per direction code.
    function automatic logic [7:0] ref_pix(input int w, input int h, input int r, input int c);
        logic [9:0] wd;
        logic [7:0] a, b;
        int dr, dc;
        if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 8'h00;
        wd = frame[r*w+c];
        case (wd[9:8])
            2'd0:    begin dr = 0;  dc = -1; end
            2'd1:    begin dr = -1; dc = 1;  end
            2'd2:    begin dr = -1; dc = 0;  end
            default: begin dr = -1; dc = -1; end
        endcase
        a = frame[(r+dr)*w+(c+dc)][7:0];
        b = frame[(r-dr)*w+(c-dc)][7:0];
        return (wd[7:0] >= a && wd[7:0] >= b) ? wd[7:0] : 8'h00;
    endfunction

    task automatic send_frame(input int ln, input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            in_q[ln].push_back(frame[i]);
            exp_q[ln].push_back({(i == w * h - 1) ? 1'b1 : 1'b0, ref_pix(w, h, i / w, i % w)});
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            pops[i] = 0; pushes[i] = 0; fd_cnt[i] = 0;
        end
    endtask

    task automatic wait_idle(input int ln, input int budget, input string name);
        int n;
        n = 0;
        while ((in_q[ln].size() != 0 || exp_q[ln].size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending need 0", name, exp_q[ln].size());
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic check_counts(input int ln, input int npix, input int nfd, input string name);
        checks++;
        if (pops[ln] != npix) begin
            errors++; $display("FAIL %s_pops got %0d need %0d", name, pops[ln], npix);
        end
        checks++;
        if (pushes[ln] != npix) begin
            errors++; $display("FAIL %s_pushes got %0d need %0d", name, pushes[ln], npix);
        end
        checks++;
        if (fd_cnt[ln] != nfd) begin
            errors++; $display("FAIL %s_frame_done_count got %0d need %0d", name, fd_cnt[ln], nfd);
        end
        $display("%s pops %0d pushes %0d frame_done %0d", name, pops[ln], pushes[ln], fd_cnt[ln]);
    endtask

    task automatic check_reset_outputs(input string name);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_rd_en[i] !== 1'b0 || out_wr_en[i] !== 1'b0 ||
                frame_done[i] !== 1'b0 || out_din[i] !== 8'h00) begin
                errors++;
                $display("FAIL %s lane%0d got rd=%b wr=%b fd=%b din=%0d need 0 0 0 0",
                         name, i, in_rd_en[i], out_wr_en[i], frame_done[i], out_din[i]);
            end
        end
    endtask

    task automatic fill_const(input int n, input logic [9:0] v);
        for (int i = 0; i < n; i++) frame[i] = v;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame[i] = 10'($urandom);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog got running need finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        stall_en[0] = 1'b0;
        stall_en[1] = 1'b0;
        clear_counts();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_state");
        #2 reset = 1'b1;

        // 1) uniform frame: ties kept in the interior, zero border
        clear_counts();
        fill_const(48, {2'd0, 8'd100});
        send_frame(0, 8, 6);
        wait_idle(0, 500, "uniform");
        check_counts(0, 48, 1, "uniform");

        // 2a) vertical ridge, horizontal gradient
        clear_counts();
        fill_const(48, 10'h000);
        for (int r = 0; r < 6; r++) begin
            frame[r*8+2] = {2'd0, 8'd150};
            frame[r*8+3] = {2'd0, 8'd200};
            frame[r*8+4] = {2'd0, 8'd120};
        end
        send_frame(0, 8, 6);
        wait_idle(0, 500, "ridge_h");
        check_counts(0, 48, 1, "ridge_h");

        // 2b) horizontal ridge, vertical gradient
        clear_counts();
        fill_const(48, {2'd2, 8'd0});
        for (int c = 0; c < 8; c++) begin
            frame[2*8+c] = {2'd2, 8'd150};
            frame[3*8+c] = {2'd2, 8'd200};
            frame[4*8+c] = {2'd2, 8'd120};
        end
        send_frame(0, 8, 6);
        wait_idle(0, 500, "ridge_v");
        check_counts(0, 48, 1, "ridge_v");

        // 3) diagonal directions
        clear_counts();
        fill_const(48, 10'h000);
        frame[2*8+2] = {2'd1, 8'd90};
        frame[1*8+3] = {2'd0, 8'd100};
        frame[3*8+1] = {2'd0, 8'd50};
        frame[2*8+5] = {2'd3, 8'd90};
        frame[1*8+4] = {2'd0, 8'd80};
        frame[3*8+6] = {2'd0, 8'd89};
        send_frame(0, 8, 6);
        wait_idle(0, 500, "diag");
        check_counts(0, 48, 1, "diag");

        // 4) random 16x8 frame with random input-empty and output-full
        clear_counts();
        stall_en[1] = 1'b1;
        fill_random(128);
        send_frame(1, 16, 8);
        wait_idle(1, 5000, "random_stall");
        check_counts(1, 128, 1, "random_stall");
        stall_en[1] = 1'b0;

        // 5) two back-to-back frames
        clear_counts();
        fill_random(48);
        send_frame(0, 8, 6);
        fill_const(48, {2'd0, 8'd7});
        for (int r = 0; r < 6; r++) frame[r*8+3] = {2'd0, 8'd200};
        send_frame(0, 8, 6);
        wait_idle(0, 1000, "back2back");
        check_counts(0, 96, 2, "back2back");

        // 6) reset in the middle of a frame, then a clean frame
        clear_counts();
        fill_random(48);
        send_frame(0, 8, 6);
        begin
            int n;
            n = 0;
            while (pushes[0] < 20 && n < 500) begin
                @(negedge clock);
                #3;
                n++;
            end
            checks++;
            if (pushes[0] < 20) begin
                errors++;
                $display("FAIL midreset_reach got %0d need 20", pushes[0]);
            end
        end
        reset = 1'b0;
        in_q[0].delete();
        exp_q[0].delete();
        check_reset_outputs("midframe_reset");
        repeat (2) @(negedge clock);
        #3 reset = 1'b1;
        clear_counts();
        fill_random(48);
        send_frame(0, 8, 6);
        wait_idle(0, 500, "after_reset");
        check_counts(0, 48, 1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
